// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive queue.
// Contents: frame state enum, scan-code prefix bytes, FIFO entry width.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam int PS2_ENTRY_W = 10;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 pins and deglitches the PS/2 clock.
// Ports: clk/clrn system clock and async active-low reset; ps2_clk/ps2_data raw pins;
//        filt_clk filtered clock (resets to 1); sample one-cycle pulse on filtered 1->0;
//        data_sync synchronised data pin, valid to capture while sample is high.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic filt_clk,
    output logic sample,
    output logic data_sync
);
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic [3:0] cnt;
    logic       flip;
    // cnt tracks how many consecutive samples disagreed with filt_clk
    assign flip      = (clk_sync[1] != filt_clk) && (cnt == 4'(FILTER_LEN - 1));
    assign data_sync = dat_sync[1];
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            cnt      <= '0;
            filt_clk <= 1'b1;
            sample   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            cnt      <= (clk_sync[1] == filt_clk || flip) ? '0 : cnt + 4'd1;
            filt_clk <= flip ? clk_sync[1] : filt_clk;
            sample   <= flip && filt_clk;
        end
    end
endmodule

// File: rtl/ps2_rx_queue.sv
// ps2_rx_queue: PS/2 device-to-host receiver with error flags and an FWFT byte queue.
// Ports: clk, clrn (async active-low reset), ps2_clk/ps2_data raw pins, rdn active-low pop;
//        data head entry {ext, brk, code}, ready FIFO non-empty, overflow/parity_err/frame_err
//        sticky flags cleared by an accepted pop, count FIFO fill level.
// Build option: define PS2_EXT_DECODE_EN to fold E0/F0 prefixes into the ext/brk bits.
module ps2_rx_queue
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         rdn,
    output logic [PS2_ENTRY_W-1:0]       data,
    output logic                         ready,
    output logic                         overflow,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic                   sample;
    logic                   data_sync;
    ps2_state_t             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par;
    logic [TW-1:0]          to_cnt;
    logic                   at_stop, good, perr, ferr, tout;
    logic                   want_push, pop, accept;
    logic [PS2_ENTRY_W-1:0] entry;
    logic [PS2_ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .filt_clk  (),
        .sample    (sample),
        .data_sync (data_sync)
    );

    // a sample in the same cycle as the limit counts as activity, not a timeout
    assign tout    = (state != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYC));
    assign at_stop = sample && (state == STOP);
    assign good    = at_stop && data_sync && (^{shreg, par});
    assign perr    = at_stop && data_sync && !(^{shreg, par});
    assign ferr    = (at_stop && !data_sync) || (sample && state == IDLE && data_sync) || tout;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else if (sample) begin
            to_cnt <= '0;
            case (state)
                IDLE: begin
                    state   <= data_sync ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: begin
                    shreg   <= {data_sync, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par   <= data_sync;
                    state <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (tout) begin
            state  <= IDLE;
            to_cnt <= '0;
            shreg  <= '0;
        end else if (state != IDLE) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

`ifdef PS2_EXT_DECODE_EN
    logic pend_ext, pend_brk, is_ext, is_brk;
    assign is_ext    = (shreg == PS2_PFX_EXT);
    assign is_brk    = (shreg == PS2_PFX_BRK);
    assign want_push = good && !is_ext && !is_brk;
    assign entry     = {pend_ext, pend_brk, shreg};
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (perr || ferr) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (good) begin
            // a prefix only sets its own flag; a key byte consumes both
            pend_ext <= is_ext ? 1'b1 : (is_brk ? pend_ext : 1'b0);
            pend_brk <= is_brk ? 1'b1 : (is_ext ? pend_brk : 1'b0);
        end
    end
`else
    assign want_push = good;
    assign entry     = {2'b00, shreg};
`endif

    assign ready  = (count != '0);
    assign data   = ready ? mem[rd_ptr] : '0;
    assign pop    = !rdn && ready;
    // a pop in the same cycle frees the slot the push needs
    assign accept = want_push && ((count != (AW+1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(accept);
            rd_ptr     <= rd_ptr + AW'(pop);
            count      <= count + (AW+1)'(accept) - (AW+1)'(pop);
            overflow   <= (want_push && !accept) || (overflow && !pop);
            parity_err <= perr || (parity_err && !pop);
            frame_err  <= ferr || (frame_err && !pop);
        end
    end
endmodule

// File: tb/tb_ps2_rx_queue.sv
// tb_ps2_rx_queue: directed self-checking bench for ps2_rx_queue.
module tb_ps2_rx_queue;
    logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rdn = 1'b1;
    logic [9:0] data;
    logic       ready, overflow, parity_err, frame_err;
    logic [4:0] count;
    int         checks = 0, errors = 0;

    ps2_rx_queue #(.FIFO_DEPTH(16), .FILTER_LEN(4), .TIMEOUT_CYC(1000)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rdn        (rdn),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        @(negedge clk) rdn = 1'b0;
        @(negedge clk) rdn = 1'b1;
    endtask

    // mode 0 plain, 1 check push latency, 2 pop on the sample cycle, 3 glitch while high
    task automatic ps2_bit(input logic b, input int mode);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (6) @(negedge clk);
            chk("lat_before", 32'(ready), 0);
            @(negedge clk);
            chk("lat_after", 32'(ready), 1);
            repeat (13) @(negedge clk);
        end else if (mode == 2) begin
            repeat (6) @(negedge clk);
            rdn = 1'b0;
            @(negedge clk);
            rdn = 1'b1;
            repeat (13) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
        end
        ps2_clk = 1'b1;
        if (mode == 3) begin
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input logic stop = 1'b1,
                        input int stop_mode = 0, input int nbits = 11, input bit glitch = 1'b0);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i], (i == 10) ? stop_mode : ((glitch && i == 4) ? 3 : 0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h1C, 1'b0, 1'b1, 1);
        chk("single_data", 32'(data), 32'h01C);
        chk("single_count", 32'(count), 1);
        pop_one();
        chk("single_pop_ready", 32'(ready), 0);
        chk("single_pop_count", 32'(count), 0);

        send(8'h1C, 1'b1);
        chk("perr_flag", 32'(parity_err), 1);
        chk("perr_count", 32'(count), 0);
        send(8'h32);
        chk("perr_next_data", 32'(data), 32'h032);
        chk("perr_still_set", 32'(parity_err), 1);
        pop_one();
        chk("perr_cleared", 32'(parity_err), 0);
        chk("perr_empty", 32'(ready), 0);

        send(8'h1C, 1'b0, 1'b1, 0, 5);
        repeat (900) @(negedge clk);
        chk("tout_early", 32'(frame_err), 0);
        repeat (100) @(negedge clk);
        chk("tout_flag", 32'(frame_err), 1);
        chk("tout_count", 32'(count), 0);
        send(8'h1C);
        chk("tout_next_data", 32'(data), 32'h01C);
        chk("tout_next_count", 32'(count), 1);
        pop_one();
        chk("tout_cleared", 32'(frame_err), 0);

        ps2_bit(1'b1, 0);
        chk("start_err_flag", 32'(frame_err), 1);
        chk("start_err_count", 32'(count), 0);
        send(8'h66);
        chk("start_err_next", 32'(data), 32'h066);
        pop_one();
        chk("start_err_cleared", 32'(frame_err), 0);
        send(8'h55, 1'b0, 1'b0);
        chk("stop_err_flag", 32'(frame_err), 1);
        chk("stop_err_count", 32'(count), 0);
        send(8'h77);
        chk("stop_err_next", 32'(data), 32'h077);
        pop_one();
        chk("stop_err_cleared", 32'(frame_err), 0);

        for (int i = 1; i <= 17; i++) send(8'(i));
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ovf_head_%0d", i), 32'(data), i);
            pop_one();
            if (i == 1) chk("ovf_cleared", 32'(overflow), 0);
        end
        chk("ovf_drained", 32'(ready), 0);

        for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
        chk("full_count", 32'(count), 16);
        send(8'h30, 1'b0, 1'b1, 2);
        chk("pushpop_count", 32'(count), 16);
        chk("pushpop_overflow", 32'(overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("pushpop_head_%0d", i), 32'(data), 32'h20 + i);
            pop_one();
        end
        chk("pushpop_drained", 32'(ready), 0);

        send(8'hE0);
        send(8'hF0);
        send(8'h75);
`ifdef PS2_EXT_DECODE_EN
        chk("ext_count", 32'(count), 1);
        chk("ext_data", 32'(data), 32'h375);
        pop_one();
`else
        chk("ext_count", 32'(count), 3);
        chk("ext_data", 32'(data), 32'h0E0);
        pop_one();
        chk("ext_data2", 32'(data), 32'h0F0);
        pop_one();
        chk("ext_data3", 32'(data), 32'h075);
        pop_one();
`endif
        chk("ext_drained", 32'(ready), 0);

        send(8'h5A, 1'b0, 1'b1, 0, 11, 1'b1);
        chk("glitch_count", 32'(count), 1);
        chk("glitch_data", 32'(data), 32'h05A);
        chk("glitch_frame_err", 32'(frame_err), 0);
        chk("glitch_parity_err", 32'(parity_err), 0);
        pop_one();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
